data_ram_arbiter: RTL and testbench

//  Shares the single-port data RAM (async read, sync byte-enabled write) between two requesters:

---
 rtl/data_ram_arbiter_pkg.sv | 20 ++
 rtl/data_ram_arbiter_rr_arbiter2.sv | 26 ++
 rtl/data_ram_arbiter.sv | 112 +++++++++++
 tb/tb_data_ram_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/data_ram_arbiter_pkg.sv
// rtl/data_ram_arbiter_pkg.sv - shared widths, port ids and state encoding for the data RAM arbiter
package data_ram_arbiter_pkg;

    localparam int RegWidth  = 32;
    localparam int ByteWidth = RegWidth / 8;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // One-hot strobe for a port id, used for the grant and completion vectors.
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DBG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_arbiter2.sv
// rtl/data_ram_arbiter_rr_arbiter2.sv - two-requester round-robin grant with pointer update
module rr_arbiter2
    import data_ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] gnt,
    output logic       rr_ptr_next
);

    // A lone requester wins outright and leaves the pointer alone; a tie goes to rr_ptr and flips it.
    always_comb begin
        gnt         = 2'b00;
        rr_ptr_next = rr_ptr;
        case (req)
            2'b01: gnt = port_onehot(PORT_LSU);
            2'b10: gnt = port_onehot(PORT_DBG);
            2'b11: begin
                gnt         = port_onehot(rr_ptr);
                rr_ptr_next = ~rr_ptr;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - round-robin sharing of the single-port data RAM between LSU and debug loader
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RegWidth,
    parameter int DATA_W = RegWidth,
    localparam int SEL_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [SEL_W-1:0]  sel0_i,
    input  logic [SEL_W-1:0]  sel1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [SEL_W-1:0]  ram_sel_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    state_t            state;
    logic              rr_ptr;
    logic              rr_ptr_next;
    logic [1:0]        arb_gnt;

    logic              lat_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [SEL_W-1:0]  lat_sel;
    logic [DATA_W-1:0] lat_wdata;

    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    rr_arbiter2 u_rr_arbiter2 (
        .req         (req_i),
        .rr_ptr      (rr_ptr),
        .gnt         (arb_gnt),
        .rr_ptr_next (rr_ptr_next)
    );

    // Grant is combinational so a requester sees it in the cycle it asks; reset silences it.
    assign gnt_o = rst ? 2'b00 : arb_gnt;

    // Grant stage latches the winner; access stage turns the latch into a one-cycle completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= PORT_LSU;
            lat_port  <= PORT_LSU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_sel   <= '0;
            lat_wdata <= '0;
            rvalid_q  <= 2'b00;
            rdata_q   <= '0;
        end else begin
            if (arb_gnt != 2'b00) begin
                state    <= ST_ACCESS;
                rr_ptr   <= rr_ptr_next;
                lat_port <= arb_gnt[1];
                if (arb_gnt[1]) begin
                    lat_we    <= we_i[1];
                    lat_addr  <= addr1_i;
                    lat_sel   <= sel1_i;
                    lat_wdata <= wdata1_i;
                end else begin
                    lat_we    <= we_i[0];
                    lat_addr  <= addr0_i;
                    lat_sel   <= sel0_i;
                    lat_wdata <= wdata0_i;
                end
            end else begin
                // Clearing the latch keeps the RAM bus at zero whenever nothing is in flight.
                state     <= ST_IDLE;
                lat_port  <= PORT_LSU;
                lat_we    <= 1'b0;
                lat_addr  <= '0;
                lat_sel   <= '0;
                lat_wdata <= '0;
            end

            if (state == ST_ACCESS) begin
                rvalid_q <= port_onehot(lat_port);
                rdata_q  <= lat_we ? '0 : ram_rdata_i;
            end else begin
                rvalid_q <= 2'b00;
                rdata_q  <= '0;
            end
        end
    end

    // The RAM bus follows the latch, but a reset landing on the access cycle pulls it low so the write is dropped.
    assign ram_en_o    = (state == ST_ACCESS) && !rst;
    assign ram_we_o    = ram_en_o && lat_we;
    assign ram_addr_o  = ram_en_o ? lat_addr  : '0;
    assign ram_sel_o   = ram_en_o ? lat_sel   : '0;
    assign ram_wdata_o = ram_en_o ? lat_wdata : '0;

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - directed self-checking bench for data_ram_arbiter with a behavioural RAM
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [31:0] addr0_i, addr1_i;
    logic [3:0]  sel0_i, sel1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        ram_en_o, ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int checks = 0;
    int errors = 0;

    logic        mem_clr;
    logic [31:0] mem [0:1023];

    data_ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .sel0_i      (sel0_i),
        .sel1_i      (sel1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_sel_o   (ram_sel_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: async read (0 when disabled), byte-enabled write on the rising edge.
    assign ram_rdata_i = ram_en_o ? mem[ram_addr_o[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[16] <= 32'h11223344;
        end else if (ram_en_o && ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel_o[b]) mem[ram_addr_o[11:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle, drive the new inputs just after the edge, then sample at the falling edge.
    task automatic cyc(input logic [1:0] r, input logic [1:0] w,
                       input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        req_i = r; we_i = w;
        addr0_i = a0; sel0_i = s0; wdata0_i = d0;
        addr1_i = a1; sel1_i = s1; wdata1_i = d1;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req_i = 2'b11; we_i = 2'b00;
        addr0_i = 0; addr1_i = 0; sel0_i = 0; sel1_i = 0; wdata0_i = 0; wdata1_i = 0;

        // 1. reset held two cycles with both requesting: everything stays quiet
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_eq("rst_gnt",    {30'b0, gnt_o}, 32'h0);
        check_eq("rst_rvalid", {30'b0, rvalid_o}, 32'h0);
        check_eq("rst_rdata",  rdata_o, 32'h0);
        check_eq("rst_ram",    {ram_en_o, ram_we_o, ram_sel_o, 26'b0}, 32'h0);
        check_eq("rst_addr",   ram_addr_o | ram_wdata_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0; req_i = 2'b00;
        @(negedge clk);
        idle();
        check_eq("idle_en", {31'b0, ram_en_o}, 32'h0);

        // 2. port 0 write then read of 0x1000
        cyc(2'b01, 2'b01, 32'h1000, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        check_eq("t2_gnt_w", {30'b0, gnt_o}, 32'h1);
        cyc(2'b01, 2'b00, 32'h1000, 4'hF, 32'h0, 0, 0, 0);
        check_eq("t2_gnt_r", {30'b0, gnt_o}, 32'h1);
        check_eq("t2_ram_we", {30'b0, ram_en_o, ram_we_o}, 32'h3);
        check_eq("t2_ram_addr", ram_addr_o, 32'h1000);
        check_eq("t2_ram_wdata", ram_wdata_o, 32'hDEADBEEF);
        idle();
        check_eq("t2_rvalid_w", {30'b0, rvalid_o}, 32'h1);
        check_eq("t2_rdata_w", rdata_o, 32'h0);
        check_eq("t2_ram_rd", {30'b0, ram_en_o, ram_we_o}, 32'h2);
        idle();
        check_eq("t2_rvalid_r", {30'b0, rvalid_o}, 32'h1);
        check_eq("t2_rdata_r", rdata_o, 32'hDEADBEEF);
        check_eq("t2_en_off", {31'b0, ram_en_o}, 32'h0);

        // 3. both ports read every cycle: alternate starting at port 0
        cyc(2'b11, 2'b00, 32'h1000, 4'hF, 0, 32'h40, 4'hF, 0);
        check_eq("t3_gnt1", {30'b0, gnt_o}, 32'h1);
        cyc(2'b11, 2'b00, 32'h1000, 4'hF, 0, 32'h40, 4'hF, 0);
        check_eq("t3_gnt2", {30'b0, gnt_o}, 32'h2);
        cyc(2'b11, 2'b00, 32'h1000, 4'hF, 0, 32'h40, 4'hF, 0);
        check_eq("t3_gnt3", {30'b0, gnt_o}, 32'h1);
        check_eq("t3_rv1", {30'b0, rvalid_o}, 32'h1);
        check_eq("t3_rd1", rdata_o, 32'hDEADBEEF);
        cyc(2'b11, 2'b00, 32'h1000, 4'hF, 0, 32'h40, 4'hF, 0);
        check_eq("t3_gnt4", {30'b0, gnt_o}, 32'h2);
        check_eq("t3_rv2", {30'b0, rvalid_o}, 32'h2);
        check_eq("t3_rd2", rdata_o, 32'h11223344);
        idle();
        check_eq("t3_rv3", {30'b0, rvalid_o}, 32'h1);
        check_eq("t3_rd3", rdata_o, 32'hDEADBEEF);
        idle();
        check_eq("t3_rv4", {30'b0, rvalid_o}, 32'h2);
        check_eq("t3_rd4", rdata_o, 32'h11223344);

        // 4. byte write, read back, sel=0 write, read back
        cyc(2'b01, 2'b01, 32'h40, 4'b0100, 32'h00AB0000, 0, 0, 0);
        cyc(2'b01, 2'b00, 32'h40, 4'b0000, 32'h0, 0, 0, 0);
        cyc(2'b01, 2'b01, 32'h40, 4'b0000, 32'hFFFFFFFF, 0, 0, 0);
        check_eq("t4_rv_bw", {30'b0, rvalid_o}, 32'h1);
        cyc(2'b01, 2'b00, 32'h40, 4'b0000, 32'h0, 0, 0, 0);
        check_eq("t4_rd_bw", rdata_o, 32'h11AB3344);
        idle();
        check_eq("t4_rv_sel0", {30'b0, rvalid_o}, 32'h1);
        check_eq("t4_rd_sel0", rdata_o, 32'h0);
        idle();
        check_eq("t4_rd_after_sel0", rdata_o, 32'h11AB3344);
        idle();

        // 5. reset during the access cycle of a write to 0x2000 (rr_ptr moved to 1 first)
        cyc(2'b11, 2'b01, 32'h2000, 4'hF, 32'hCAFEF00D, 32'h40, 4'hF, 0);
        check_eq("t5_gnt", {30'b0, gnt_o}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; req_i = 2'b00; we_i = 2'b00;
        @(negedge clk);
        check_eq("t5_ram_dropped", {30'b0, ram_en_o, ram_we_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_no_rvalid", {30'b0, rvalid_o}, 32'h0);
        check_eq("t5_rdata", rdata_o, 32'h0);
        check_eq("t5_ram_off", {30'b0, ram_en_o, ram_we_o} | ram_addr_o, 32'h0);

        // 6. port 1 alone three cycles (reading 0x2000), then both: port 0 still first
        cyc(2'b10, 2'b00, 0, 0, 0, 32'h2000, 4'hF, 0);
        check_eq("t6_gnt_a", {30'b0, gnt_o}, 32'h2);
        cyc(2'b10, 2'b00, 0, 0, 0, 32'h2000, 4'hF, 0);
        check_eq("t6_gnt_b", {30'b0, gnt_o}, 32'h2);
        cyc(2'b10, 2'b00, 0, 0, 0, 32'h2000, 4'hF, 0);
        check_eq("t6_gnt_c", {30'b0, gnt_o}, 32'h2);
        check_eq("t6_rv", {30'b0, rvalid_o}, 32'h2);
        check_eq("t6_rd_unwritten", rdata_o, 32'hDEADBEEF);
        cyc(2'b11, 2'b00, 32'h40, 0, 0, 32'h2000, 4'hF, 0);
        check_eq("t6_tie_port0", {30'b0, gnt_o}, 32'h1);
        cyc(2'b10, 2'b00, 0, 0, 0, 32'h2000, 4'hF, 0);
        check_eq("t6_then_port1", {30'b0, gnt_o}, 32'h2);
        idle();
        check_eq("t6_rv_p0", {30'b0, rvalid_o}, 32'h1);
        check_eq("t6_rd_p0", rdata_o, 32'h11AB3344);
        idle();
        check_eq("t6_rv_p1", {30'b0, rvalid_o}, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
